// File: rtl/dma_timing_control.sv
// DMA bus-cycle timing controller: sequences SI/S0..S4 and drives hold, address and command strobes.
// Build option: define DMA_EXT_WRITE_EN to assert the write strobe from S2 (extended write).
module dma_timing_control #(
  parameter int NUM_CH = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ValidReqID,
  input  logic [1:0]        ReqID,
  input  logic              Hlda,
  input  logic              Ready,
  input  logic              Tc,
  input  logic              EopIn_n,
  input  logic [1:0]        Mode,
  input  logic [1:0]        XferType,
  input  logic              SenseDack,
  input  logic              Dma_Disable,
  output logic              Hrq,
  output logic [NUM_CH-1:0] Dack,
  output logic              Aen,
  output logic              Adstb,
  output logic              Ior_n,
  output logic              Iow_n,
  output logic              Memr_n,
  output logic              Memw_n,
  output logic              EopOut_n,
  output logic              AddrStep,
  output logic [1:0]        ChanSel
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} stateType;

  stateType state, nextState;
  logic     stopPending;   // EOP seen or disable raised during this transfer
  logic     inTransfer;
  logic     readPhase;
  logic     writePhase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= SI;
    else          state <= nextState;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ChanSel     <= 2'd0;
      stopPending <= 1'b0;
    end else if (state == SI) begin
      stopPending <= 1'b0;
      if (ValidReqID && !Dma_Disable) ChanSel <= ReqID;
    end else if (((state inside {S2, S3, S4}) && !EopIn_n) || Dma_Disable) begin
      stopPending <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      SI: if (ValidReqID && !Dma_Disable) nextState = S0;
      S0: if (Hlda) nextState = S1;
      S1: nextState = Hlda ? S2 : SI;
      S2: nextState = Hlda ? S3 : SI;
      S3: begin
        if (!Hlda)      nextState = SI;
        else if (Ready) nextState = S4;
      end
      S4: begin
        if (!Hlda || Tc || stopPending || !EopIn_n || Dma_Disable) begin
          nextState = SI;
        end else begin
          unique case (Mode)
            2'b10:   nextState = S1;
            2'b00:   nextState = (ValidReqID && (ReqID == ChanSel)) ? S1 : SI;
            default: nextState = SI;
          endcase
        end
      end
      default: nextState = SI;
    endcase
  end

  assign inTransfer = state inside {S1, S2, S3, S4};
  assign readPhase  = state inside {S2, S3};
`ifdef DMA_EXT_WRITE_EN
  assign writePhase = state inside {S2, S3};
`else
  assign writePhase = (state == S3);
`endif

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    Hrq      = (state != SI);
    Aen      = inTransfer;
    Adstb    = (state == S1);
    Dack     = {NUM_CH{~SenseDack}};
    Ior_n    = 1'b1;
    Iow_n    = 1'b1;
    Memr_n   = 1'b1;
    Memw_n   = 1'b1;
    EopOut_n = 1'b1;
    AddrStep = 1'b0;
    if (inTransfer) Dack[ChanSel] = SenseDack;
    unique case (XferType)
      2'b01: begin
        Ior_n  = ~readPhase;
        Memw_n = ~writePhase;
      end
      2'b10: begin
        Memr_n = ~readPhase;
        Iow_n  = ~writePhase;
      end
      default: ;
    endcase
    // A transfer cut short by a falling Hlda never steps the address counter.
    if ((state == S4) && Hlda) begin
      AddrStep = 1'b1;
      EopOut_n = ~Tc;
    end
  end

endmodule

// File: tb/tb_dma_timing_control.sv
// Directed bench for dma_timing_control: per-cycle stimulus tables with hand-derived bus phases.
module tb_dma_timing_control;

  localparam int PH_SI = 0, PH_S0 = 1, PH_S1 = 2, PH_S2 = 3, PH_S3 = 4, PH_S4 = 5;

  typedef struct {
    logic       valid;
    logic [1:0] req;
    logic       hlda, ready, tc, eopN, dis;
    int         phase;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Reset_n, ValidReqID, Hlda, Ready, Tc, EopIn_n, SenseDack, Dma_Disable;
  logic [1:0] ReqID, Mode, XferType;
  logic       Hrq, Aen, Adstb, Ior_n, Iow_n, Memr_n, Memw_n, EopOut_n, AddrStep;
  logic [3:0] Dack;
  logic [1:0] ChanSel;

  logic [14:0] obs, expv;
  logic [1:0]  expChan;
  int checks = 0, failures = 0, stepCount = 0, stepBase;

  always #5 Clock = ~Clock;

  dma_timing_control #(.NUM_CH(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ValidReqID(ValidReqID), .ReqID(ReqID),
    .Hlda(Hlda), .Ready(Ready), .Tc(Tc), .EopIn_n(EopIn_n), .Mode(Mode),
    .XferType(XferType), .SenseDack(SenseDack), .Dma_Disable(Dma_Disable),
    .Hrq(Hrq), .Dack(Dack), .Aen(Aen), .Adstb(Adstb), .Ior_n(Ior_n), .Iow_n(Iow_n),
    .Memr_n(Memr_n), .Memw_n(Memw_n), .EopOut_n(EopOut_n), .AddrStep(AddrStep),
    .ChanSel(ChanSel)
  );

  assign obs = {Hrq, Aen, Adstb, Ior_n, Iow_n, Memr_n, Memw_n, EopOut_n, AddrStep, Dack, ChanSel};

  always @(posedge Clock) if (AddrStep === 1'b1) stepCount++;

  // Expected pin levels for a given bus phase.
  function automatic logic [14:0] expOut(int phase, logic [1:0] xfer, logic tc, logic sense,
                                         logic [1:0] chan);
    logic rd, wr, ior, iow, memr, memw;
    logic [3:0] dk;
    rd = (phase == PH_S2) || (phase == PH_S3);
`ifdef DMA_EXT_WRITE_EN
    wr = rd;
`else
    wr = (phase == PH_S3);
`endif
    ior = 1'b1; iow = 1'b1; memr = 1'b1; memw = 1'b1;
    if (xfer == 2'b01) begin ior = ~rd; memw = ~wr; end
    else if (xfer == 2'b10) begin memr = ~rd; iow = ~wr; end
    dk = {4{~sense}};
    if (phase >= PH_S1) dk[chan] = sense;
    return {phase >= PH_S0, phase >= PH_S1, phase == PH_S1, ior, iow, memr, memw,
            ~((phase == PH_S4) && tc), phase == PH_S4, dk, chan};
  endfunction

  function automatic vec_t mk(logic valid, logic [1:0] req, logic hlda, logic ready, logic tc,
                              logic eopN, logic dis, int phase);
    vec_t v;
    v.valid = valid; v.req = req; v.hlda = hlda; v.ready = ready;
    v.tc = tc; v.eopN = eopN; v.dis = dis; v.phase = phase;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ValidReqID = v.valid; ReqID = v.req; Hlda = v.hlda; Ready = v.ready;
    Tc = v.tc; EopIn_n = v.eopN; Dma_Disable = v.dis;
  endtask

  task automatic setup(input logic [1:0] m, input logic [1:0] x, input logic s);
    Mode = m; XferType = x; SenseDack = s; stepBase = stepCount;
  endtask

  task automatic test_reset;
    Reset_n = 1'b1; ValidReqID = 1'b1; ReqID = 2'd3; Hlda = 1'b0; Ready = 1'b1; Tc = 1'b0;
    EopIn_n = 1'b1; Dma_Disable = 1'b0; Mode = 2'b01; XferType = 2'b01; SenseDack = 1'b1;
    #1 Reset_n = 1'b0;
    #2;
    expChan = 2'd0;
    expv = expOut(PH_SI, 2'b01, 1'b0, 1'b1, 2'd0);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_sense1: got %b expected %b", obs, expv); end
    SenseDack = 1'b0;
    @(negedge Clock);
    expv = expOut(PH_SI, 2'b01, 1'b0, 1'b0, 2'd0);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_sense0_held: got %b expected %b", obs, expv); end
    ValidReqID = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    vec_t v[$];
    setup(2'b01, 2'b01, 1'b1);
    v.push_back(mk(1, 2, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 2, 0, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 2, 0, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S4));
    v.push_back(mk(0, 2, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL single_write cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 1) begin failures++; $display("FAIL single_write_steps: got %0d expected 1", stepCount - stepBase); end
  endtask

  task automatic test_block_read_tc;
    vec_t v[$];
    setup(2'b10, 2'b10, 1'b0);
    v.push_back(mk(1, 1, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S0));
    for (int k = 0; k < 3; k++) begin
      v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S1));
      v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S2));
      v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S3));
      v.push_back(mk(0, 1, 1, 1, logic'(k == 2), 1, 0, PH_S4));
    end
    v.push_back(mk(0, 1, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL block_read cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 3) begin failures++; $display("FAIL block_read_steps: got %0d expected 3", stepCount - stepBase); end
  endtask

  task automatic test_ready_wait;
    vec_t v[$];
    setup(2'b11, 2'b10, 1'b1);
    v.push_back(mk(1, 0, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 0, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 0, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 0, 1, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 0, 1, 0, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 0, 1, 1, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 0, 1, 1, 0, 1, 0, PH_S4));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL ready_wait cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 1) begin failures++; $display("FAIL ready_wait_steps: got %0d expected 1", stepCount - stepBase); end
  endtask

  // Demand-mode verify; ReqID wanders mid-transfer to show ChanSel stays latched.
  task automatic test_demand_verify;
    vec_t v[$];
    setup(2'b00, 2'b00, 1'b1);
    v.push_back(mk(1, 3, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(1, 3, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(1, 0, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(1, 0, 1, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(1, 0, 1, 1, 0, 1, 0, PH_S3));
    v.push_back(mk(1, 3, 1, 1, 0, 1, 0, PH_S4));
    v.push_back(mk(1, 3, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(1, 3, 1, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(1, 3, 1, 1, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 0, PH_S4));
    v.push_back(mk(0, 3, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL demand cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 2) begin failures++; $display("FAIL demand_steps: got %0d expected 2", stepCount - stepBase); end
  endtask

  task automatic test_hlda_drop;
    vec_t v[$];
    setup(2'b01, 2'b01, 1'b1);
    v.push_back(mk(1, 1, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 1, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 1, 0, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(0, 1, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 1, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL hlda_drop cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 0) begin failures++; $display("FAIL hlda_drop_steps: got %0d expected 0", stepCount - stepBase); end
  endtask

  // Block mode would loop, but an external EOP in S2 ends the run after this transfer.
  task automatic test_eop_in;
    vec_t v[$];
    setup(2'b10, 2'b01, 1'b0);
    v.push_back(mk(1, 2, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 2, 1, 1, 0, 0, 0, PH_S2));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S3));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S4));
    v.push_back(mk(0, 2, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL eop_in cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 1) begin failures++; $display("FAIL eop_in_steps: got %0d expected 1", stepCount - stepBase); end
  endtask

  task automatic test_disable_mid;
    vec_t v[$];
    setup(2'b10, 2'b10, 1'b1);
    v.push_back(mk(1, 3, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 1, PH_S2));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 1, PH_S3));
    v.push_back(mk(0, 3, 1, 1, 0, 1, 1, PH_S4));
    v.push_back(mk(1, 0, 1, 1, 0, 1, 1, PH_SI));
    v.push_back(mk(0, 0, 0, 1, 0, 1, 0, PH_SI));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL disable_mid cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    checks++;
    if (stepCount - stepBase !== 1) begin failures++; $display("FAIL disable_mid_steps: got %0d expected 1", stepCount - stepBase); end
  endtask

  task automatic test_reset_mid;
    vec_t v[$];
    setup(2'b01, 2'b01, 1'b1);
    v.push_back(mk(1, 2, 0, 1, 0, 1, 0, PH_SI));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S0));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S1));
    v.push_back(mk(0, 2, 1, 1, 0, 1, 0, PH_S2));
    v.push_back(mk(0, 2, 1, 0, 0, 1, 0, PH_S3));
    foreach (v[i]) begin
      @(negedge Clock); drive(v[i]); #1;
      expv = expOut(v[i].phase, XferType, v[i].tc, SenseDack, expChan);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reset_mid cyc%0d: got %b expected %b", i, obs, expv); end
      if (v[i].phase == PH_SI && v[i].valid && !v[i].dis) expChan = v[i].req;
    end
    #1 Reset_n = 1'b0;
    #1;
    expChan = 2'd0;
    expv = expOut(PH_SI, XferType, 1'b0, 1'b1, 2'd0);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_mid_async: got %b expected %b", obs, expv); end
    checks++;
    if (Dack !== 4'b0000) begin failures++; $display("FAIL reset_mid_dack: got %b expected 0000", Dack); end
    @(negedge Clock);
    Hlda = 1'b0; ValidReqID = 1'b0; Ready = 1'b1;
    Reset_n = 1'b1;
    @(negedge Clock); #1;
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_mid_after: got %b expected %b", obs, expv); end
    checks++;
    if (stepCount - stepBase !== 0) begin failures++; $display("FAIL reset_mid_steps: got %0d expected 0", stepCount - stepBase); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_block_read_tc();
    test_ready_wait();
    test_demand_verify();
    test_hlda_drop();
    test_eop_in();
    test_disable_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_timing_control.md
DMA_TIMING_CONTROL -- requirements
Module: dma_timing_control

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of DMA channels (fixed at 4; other values unsupported).
REQ-002 The block SHALL have port Clock, input, 1, meaning system clock; all state SHALL change on posedge Clock.
REQ-003 The block SHALL have port Reset_n, input, 1, meaning reset: asynchronous, active-low.
REQ-004 The block SHALL have port ValidReqID, input, 1, meaning the arbiter has a granted request.
REQ-005 The block SHALL have port ReqID, input, 2, meaning the granted channel number.
REQ-006 The block SHALL have port Hlda, input, 1, meaning hold acknowledge from the CPU.
REQ-007 The block SHALL have port Ready, input, 1, meaning memory/IO ready; 0 inserts wait states.
REQ-008 The block SHALL have port Tc, input, 1, meaning the selected channel's count expires on this transfer.
REQ-009 The block SHALL have port EopIn_n, input, 1, meaning external end-of-process, active-low.
REQ-010 The block SHALL have port Mode, input, 2, meaning the selected channel's mode: 00 demand, 01 single, 10 block, 11 treated as single.
REQ-011 The block SHALL have port XferType, input, 2, meaning 00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 treated as verify.
REQ-012 The block SHALL have port SenseDack, input, 1, meaning Dack polarity: 1 active-high, 0 active-low.
REQ-013 The block SHALL have port Dma_Disable, input, 1, meaning block new transfers.
REQ-014 The block SHALL have port Hrq, output, 1, meaning hold request to the CPU.
REQ-015 The block SHALL have port Dack, output, 4, meaning channel acknowledge, polarity set by SenseDack.
REQ-016 The block SHALL have port Aen and Adstb, output, 1 each, meaning address enable and address strobe.
REQ-017 The block SHALL have port Ior_n, Iow_n, Memr_n, Memw_n, output, 1 each, meaning bus command strobes, active-low.
REQ-018 The block SHALL have port EopOut_n, output, 1, meaning terminal-count indication, active-low.
REQ-019 The block SHALL have port AddrStep, output, 1, meaning a one-cycle pulse telling the address/count block to update.
REQ-020 The block SHALL have port ChanSel, output, 2, meaning the latched active channel.

Function
REQ-021 The FSM SHALL have states SI, S0, S1, S2, S3 and S4, one Clock each except where noted.
- SI: ValidReqID=1 and Dma_Disable=0 -> S0; ReqID is latched into ChanSel.
- S0: Hrq=1; remain in S0 until Hlda=1, then -> S1.
- S1: Adstb=1 for this cycle only -> S2.
- S2: the read strobe asserts (Ior_n for write, Memr_n for read) -> S3.
- S3: the write strobe asserts (Memw_n for write, Iow_n for read); Ready=0 holds S3 as a wait state; Ready=1 -> S4.
- S4: all strobes deassert; AddrStep=1 for one cycle.
REQ-022 Hrq SHALL be 1 in S0 through S4.
REQ-023 Aen and Dack[ChanSel] SHALL be active in S1 through S4.
REQ-024 All Dack lines other than Dack[ChanSel] SHALL be inactive at all times.
REQ-025 For verify transfers, the block SHALL assert no command strobes.
REQ-026 In S4, if Tc=1 the block SHALL drive EopOut_n=0 for that cycle and go to SI.
REQ-027 In S4, if EopIn_n=0 is sampled in S2, S3 or S4, the block SHALL go to SI.
REQ-028 Otherwise, S4 SHALL transition by mode:
- single: -> SI.
- block: -> S1.
- demand: -> S1 if ValidReqID=1 and ReqID==ChanSel; else -> SI.
REQ-029 If Hlda falls in S1 through S4, the block SHALL deassert all strobes in the next cycle, skip AddrStep, and go to SI.
REQ-030 If Dma_Disable rises mid-transfer, the current transfer SHALL complete through S4 and the block SHALL then go to SI.
REQ-031 ChanSel SHALL remain stable from S0 through S4, regardless of ReqID changes.
REQ-032 Inactive Dack level SHALL be ~SenseDack.

Reset
REQ-033 Reset_n=0 SHALL immediately (asynchronously) force state SI.
REQ-034 During reset: Hrq=0, Aen=0, Adstb=0, AddrStep=0, ChanSel=0, all command strobes=1, EopOut_n=1, and Dack=4{~SenseDack}.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer with no AddrStep pulse.

Configuration
REQ-036 Macro DMA_EXT_WRITE_EN defined: the write strobe SHALL assert in S2 together with the read strobe and hold through S3. Undefined: the write strobe SHALL assert in S3 only.

Verification
REQ-037 Single write, ReqID=2, Hlda 2 cycles after Hrq, Ready=1 -> Hrq, then S1-S4 with Dack[2] active, Ior_n S2-S3, Memw_n S3, one AddrStep, return to SI.
REQ-038 Block read, Tc=1 on the 3rd transfer -> three S1-S4 loops without S0, EopOut_n=0 in the 3rd S4, then SI with Hrq=0.
REQ-039 Ready=0 for 3 cycles in S3 -> S3 lasts 4 cycles with strobes held; exactly one AddrStep.
REQ-040 Demand mode with ValidReqID dropped after the 2nd transfer -> two transfers, then SI.
REQ-041 Hlda dropped in S2 -> strobes high next cycle, no AddrStep, SI.
REQ-042 Reset_n pulsed low in S3 with SenseDack=1 -> Dack=0000 and all reset values immediately, without waiting for a clock edge.
